beam_readout_ctrl: RTL and testbench
====================================

Name: beam_readout_ctrl

Overview:
- Sequencer between the beamformer sum output, the 40-bit readout RAM and the UART transmitter.
- On arm, captures one burst of summed samples into RAM.
- Then reads the samples back and sends each one as DATA_W/8 bytes, LSB first, through a start/busy handshake with the UART.
- Replaces ad-hoc top-level mode logic; all RAM and UART sequencing lives in one synchronous FSM.

Parameters:
- DATA_W, 40, sample width; must be a multiple of 8.
- DEPTH, 540, maximum samples stored per burst.
- ADDR_W, 10, RAM address width; 2^ADDR_W >= DEPTH.
- RD_LAT, 2, cycles from ram_rden/ram_addr to valid ram_q.
- HDR_EN, 1, when 1 the frame is prefixed with sync bytes 0xA5, 0x5A and a 16-bit LSB-first sample count.

Ports:
- clk  in  1  system clock (PLL c0).
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse; starts a burst; honoured only in IDLE.
- abort  in  1  level; forces return to IDLE from any state.
- sum_active  in  1  high while the beamformer produces a burst (sumflag).
- sum_valid  in  1  qualifies sum_data for one cycle.
- sum_data  in  DATA_W  summed beam value.
- ram_addr  out  ADDR_W  RAM address.
- ram_wren  out  1  RAM write enable.
- ram_rden  out  1  RAM read enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_q  in  DATA_W  RAM read data.
- tx_start  out  1  one-cycle pulse requesting a byte transmit.
- tx_data  out  8  byte to transmit; stable from the tx_start cycle until tx_busy falls.
- tx_busy  in  1  UART busy.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE until the next arm or abort.
- overflow  out  1  sticky per burst; a sample arrived with count == DEPTH.
- sample_count  out  ADDR_W  samples captured in the current burst.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- IDLE -> WAIT_ACT on arm. arm while busy is ignored.
- WAIT_ACT -> CAPTURE on the first cycle sum_active=1. A sum_valid in that same cycle is captured.
- CAPTURE write rules:
  - On each sum_valid with count < DEPTH: ram_wren=1, ram_addr=count, ram_wdata=sum_data, count+1 (registered, 1-cycle write latency).
  - sum_valid with count == DEPTH: no write, overflow=1.
  - sum_valid with sum_active=0 is ignored.
- CAPTURE -> HDR when sum_active falls; goes to RD_ISSUE instead if HDR_EN=0.
- count==0 at the end of CAPTURE: send the header only if enabled, then DONE; no RAM reads.
- HDR: sends 4 bytes via the byte handshake, then RD_ISSUE.
- RD_ISSUE: ram_rden=1, ram_addr=rd_idx, then RD_WAIT for RD_LAT cycles. Latch ram_q into a shift register, byte_idx=0.
- SEND: byte handshake on shift[7:0]; shift right by 8; byte_idx+1. After DATA_W/8 bytes, rd_idx+1.
  - rd_idx == count: go to DONE.
  - Otherwise RD_ISSUE.
- Byte handshake:
  - Wait for tx_busy=0, then pulse tx_start for 1 cycle.
  - Wait for tx_busy=1 (rise), then tx_busy=0 (fall); only then is the byte complete.
  - A tx_busy rise in the cycle after tx_start is legal.
  - No byte is ever started while tx_busy=1.
- DONE: done=1; arm -> WAIT_ACT; clears count, overflow, rd_idx.
- abort:
  - Synchronous; next state IDLE; counters cleared.
  - A byte already started is not cancelled in the UART; tx_start is never re-pulsed.
- rst_n low mid-burst: immediate return to reset values; RAM contents undefined to software.
- ram_wren and ram_rden are never high in the same cycle.

Decomposition:
- Package beam_pkg: state enum, SYNC0=8'hA5, SYNC1=8'h5A, DATA_W/DEPTH defaults, BYTES=DATA_W/8.
- One sub-module, byte_tx_handshake: inputs go, byte, tx_busy; outputs tx_start, tx_data, byte_done. Reused for header and payload bytes.

Test Plan:
- Reset: rst_n low mid-SEND -> all outputs 0 within same cycle, state IDLE, no tx_start after release until arm.
- 3-sample burst, HDR_EN=1:
  - Stimulus: sums 0x0102030405, 0xAABBCCDDEE, 0x0, with a UART model busy for 10 cycles.
  - Byte stream: A5 5A 03 00 05 04 03 02 01 EE DD CC BB AA 00 00 00 00 00.
  - done=1, sample_count=3.
- Overflow: 545 sum_valid pulses -> 540 RAM writes (addr 0..539), overflow=1, 2700 payload bytes.
- Empty burst: sum_active high 5 cycles with no sum_valid -> only header A5 5A 00 00, then done.
- Handshake: UART holds tx_busy=1 for 200 cycles at arm time -> first tx_start only after busy falls; exactly one tx_start per byte.
- Ignore and abort:
  - arm during CAPTURE has no effect.
  - abort during RD_WAIT -> IDLE next cycle, no further tx_start.
  - A new arm then completes a full frame.

Source files
------------

// File: rtl/beam_pkg.sv
// Shared types and constants for the beam readout sequencer and its UART byte handshake.
package beam_pkg;

   localparam int DATA_W_DEF = 40;
   localparam int DEPTH_DEF  = 540;
   localparam int ADDR_W_DEF = 10;
   localparam int RD_LAT_DEF = 2;
   localparam int BYTES      = DATA_W_DEF / 8;

   localparam logic [7:0] SYNC0 = 8'hA5;
   localparam logic [7:0] SYNC1 = 8'h5A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_ACT,
      ST_CAPTURE,
      ST_HDR,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_SEND,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_WAIT_FREE,
      HS_WAIT_RISE,
      HS_WAIT_FALL
   } hs_state_t;

   // Frame header: two sync bytes followed by the sample count, LSB first.
   function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] count);
      case (idx)
         2'd0:    return SYNC0;
         2'd1:    return SYNC1;
         2'd2:    return count[7:0];
         default: return count[15:8];
      endcase
   endfunction

endpackage

// File: rtl/byte_tx_handshake.sv
// One-byte start/busy handshake with the UART: waits for idle, pulses tx_start,
// then reports completion only after the UART's busy has risen and fallen again.
module byte_tx_handshake
   import beam_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       go,
   input  logic [7:0] tx_byte,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       byte_done
);

   hs_state_t hs_q, hs_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hs_q <= HS_IDLE;
      else        hs_q <= hs_d;
   end

   // tx_data is captured when the request is accepted and held through the whole UART transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 tx_data <= '0;
      else if (hs_q == HS_IDLE && go && !clear)  tx_data <= tx_byte;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      hs_d      = hs_q;
      tx_start  = 1'b0;
      byte_done = 1'b0;
      unique case (hs_q)
         HS_IDLE:      if (go) hs_d = HS_WAIT_FREE;
         HS_WAIT_FREE: if (!tx_busy) begin
            tx_start = 1'b1;
            hs_d     = HS_WAIT_RISE;
         end
         HS_WAIT_RISE: if (tx_busy) hs_d = HS_WAIT_FALL;
         HS_WAIT_FALL: if (!tx_busy) begin
            byte_done = 1'b1;
            hs_d      = HS_IDLE;
         end
         default:      hs_d = HS_IDLE;
      endcase
      // A byte already handed to the UART finishes there; we just forget about it.
      if (clear) begin
         hs_d      = HS_IDLE;
         tx_start  = 1'b0;
         byte_done = 1'b0;
      end
   end

endmodule

// File: rtl/beam_readout_ctrl.sv
// Captures one beamformer burst into the readout RAM, then streams it (optionally
// behind a sync/count header) to the UART one byte at a time, LSB first.
module beam_readout_ctrl
   import beam_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF,
   parameter bit HDR_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              abort,
   input  logic              sum_active,
   input  logic              sum_valid,
   input  logic [DATA_W-1:0] sum_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic              ram_rden,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_q,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W-1:0] sample_count
);

   localparam int N_BYTES = DATA_W / 8;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, rd_idx_q, wr_addr_q;
   logic [DATA_W-1:0] wr_data_q, shift_q;
   logic              wr_en_q, overflow_q;
   logic [3:0]        byte_idx_q, lat_q;
   logic              sample_ok, wr_fire, ov_fire, restart, last_byte, rd_capture;
   logic              hs_go, byte_done;
   logic [7:0]        hs_byte;

   assign sample_ok  = (state_q == ST_WAIT_ACT || state_q == ST_CAPTURE)
                       && sum_active && sum_valid && !abort;
   assign wr_fire    = sample_ok && (cnt_q < ADDR_W'(DEPTH));
   assign ov_fire    = sample_ok && !wr_fire;
   assign restart    = arm && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
   assign last_byte  = (state_q == ST_HDR) ? (byte_idx_q == 4'd3)
                                           : (byte_idx_q == 4'(N_BYTES - 1));
   assign rd_capture = (state_q == ST_RD_WAIT) && (lat_q == 4'(RD_LAT));
   assign hs_go      = (state_q == ST_HDR) || (state_q == ST_SEND);
   assign hs_byte    = (state_q == ST_HDR) ? hdr_byte(byte_idx_q[1:0], 16'(cnt_q))
                                           : shift_q[7:0];

   assign ram_wren     = wr_en_q;
   assign ram_wdata    = wr_data_q;
   assign ram_addr     = ram_rden ? rd_idx_q : wr_addr_q;
   assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done         = (state_q == ST_DONE);
   assign overflow     = overflow_q;
   assign sample_count = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      ram_rden = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: if (arm) state_d = ST_WAIT_ACT;
         ST_WAIT_ACT:      if (sum_active) state_d = ST_CAPTURE;
         ST_CAPTURE:       if (!sum_active) begin
            if (HDR_EN)            state_d = ST_HDR;
            else if (cnt_q == '0)  state_d = ST_DONE;
            else                   state_d = ST_RD_ISSUE;
         end
         ST_HDR:           if (byte_done && last_byte)
            state_d = (cnt_q == '0) ? ST_DONE : ST_RD_ISSUE;
         ST_RD_ISSUE: begin
            ram_rden = 1'b1;
            state_d  = ST_RD_WAIT;
         end
         ST_RD_WAIT:       if (rd_capture) state_d = ST_SEND;
         ST_SEND:          if (byte_done && last_byte)
            state_d = (rd_idx_q + ADDR_W'(1) == cnt_q) ? ST_DONE : ST_RD_ISSUE;
         default:          state_d = ST_IDLE;
      endcase
      if (abort) begin
         state_d  = ST_IDLE;
         ram_rden = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         rd_idx_q   <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         shift_q    <= '0;
         wr_en_q    <= 1'b0;
         overflow_q <= 1'b0;
         byte_idx_q <= '0;
         lat_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
         wr_en_q <= wr_fire;
         if (wr_fire) begin
            wr_addr_q <= cnt_q;
            wr_data_q <= sum_data;
            cnt_q     <= cnt_q + ADDR_W'(1);
         end
         if (ov_fire) overflow_q <= 1'b1;

         if (state_q == ST_RD_ISSUE)     lat_q <= 4'd1;
         else if (state_q == ST_RD_WAIT) lat_q <= lat_q + 4'd1;

         if (rd_capture) begin
            shift_q    <= ram_q;
            byte_idx_q <= '0;
         end

         if (hs_go && byte_done) begin
            byte_idx_q <= last_byte ? 4'd0 : byte_idx_q + 4'd1;
            if (state_q == ST_SEND) begin
               shift_q <= shift_q >> 8;
               if (last_byte) rd_idx_q <= rd_idx_q + ADDR_W'(1);
            end
         end

         // A new burst or an abort starts from clean counters.
         if (abort || restart) begin
            cnt_q      <= '0;
            rd_idx_q   <= '0;
            overflow_q <= 1'b0;
            byte_idx_q <= '0;
         end
      end
   end

   byte_tx_handshake u_byte_tx (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (abort),
      .go        (hs_go),
      .tx_byte   (hs_byte),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .byte_done (byte_done)
   );

endmodule

// File: tb/tb_beam_readout_ctrl.sv
// Directed bench for beam_readout_ctrl: RAM and UART models, byte and write scoreboards.
module tb_beam_readout_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arm = 1'b0, abort = 1'b0, sum_active = 1'b0, sum_valid = 1'b0;
   logic [39:0] sum_data = '0;
   logic [9:0]  ram_addr;
   logic        ram_wren, ram_rden;
   logic [39:0] ram_wdata;
   logic [39:0] ram_q = '0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        busy, done, overflow;
   logic [9:0]  sample_count;

   int n_cmp = 0, n_err = 0;
   int n_start = 0, n_writes = 0, n_reads = 0;
   int busy_len = 10, busy_cnt = 0;
   logic uart_busy = 1'b0, hold_busy = 1'b0;

   logic [7:0]  exp_q[$];
   logic [49:0] wr_q[$];
   logic [39:0] stim_q[$];
   logic [39:0] mem [0:1023];
   logic [39:0] pipe1 = '0;
   logic [49:0] wr_e;

   always #5 clk = ~clk;
   assign tx_busy = uart_busy | hold_busy;

   beam_readout_ctrl dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
      .sum_active(sum_active), .sum_valid(sum_valid), .sum_data(sum_data),
      .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_rden(ram_rden),
      .ram_wdata(ram_wdata), .ram_q(ram_q),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .busy(busy), .done(done), .overflow(overflow), .sample_count(sample_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Two-cycle read latency RAM.
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      pipe1 <= ram_rden ? mem[ram_addr] : 40'h0;
      ram_q <= pipe1;
   end

   // UART: busy rises the cycle after tx_start and stays up busy_len cycles.
   always @(posedge clk) begin
      if (tx_start) begin
         uart_busy <= 1'b1;
         busy_cnt  <= busy_len;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         busy_cnt  <= 0;
         uart_busy <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (ram_rden) n_reads++;
         if (ram_wren || ram_rden) check("wr_rd_excl", 64'(ram_wren & ram_rden), 64'd0);
         if (ram_wren) begin
            n_writes++;
            if (wr_q.size() == 0) check("wr_unexpected", 64'(ram_wren), 64'd0);
            else begin
               wr_e = wr_q.pop_front();
               check("wr_addr", 64'(ram_addr), 64'(wr_e[49:40]));
               check("wr_data", 64'(ram_wdata), 64'(wr_e[39:0]));
            end
         end
         if (tx_start) begin
            n_start++;
            check("start_while_busy", 64'(tx_busy), 64'd0);
            if (exp_q.size() == 0) check("tx_unexpected", 64'(tx_start), 64'd0);
            else check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic run_burst(input bit arm_mid, input int idle_cycles);
      logic [39:0] smp[$];
      int n;
      @(negedge clk); arm = 1'b1;
      @(negedge clk); arm = 1'b0; sum_active = 1'b1;
      repeat (idle_cycles) @(negedge clk);
      n = stim_q.size();
      for (int i = 0; i < n; i++) begin
         sum_valid = 1'b1;
         sum_data  = stim_q[i];
         if (i < 540) begin
            wr_q.push_back({10'(i), stim_q[i]});
            smp.push_back(stim_q[i]);
         end
         @(negedge clk); sum_valid = 1'b0;
         if (arm_mid && i == 0) arm = 1'b1;
         @(negedge clk); arm = 1'b0;
      end
      sum_active = 1'b0; sum_valid = 1'b1; sum_data = '1;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'(smp.size()));
      exp_q.push_back(8'(smp.size() >> 8));
      foreach (smp[j])
         for (int b = 0; b < 5; b++) exp_q.push_back(smp[j][8*b +: 8]);
      @(negedge clk); sum_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("done", 64'(done), 64'd1);
      check("bytes_left", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_ovf"}, 64'(overflow), 64'd0);
      check({tag, "_cnt"}, 64'(sample_count), 64'd0);
      check({tag, "_start"}, 64'(tx_start), 64'd0);
      check({tag, "_wren"}, 64'(ram_wren), 64'd0);
      check({tag, "_rden"}, 64'(ram_rden), 64'd0);
      check({tag, "_addr"}, 64'(ram_addr), 64'd0);
      check({tag, "_wdata"}, 64'(ram_wdata), 64'd0);
      check({tag, "_txdata"}, 64'(tx_data), 64'd0);
   endtask

   initial begin
      int s0, s1, g;

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Three-sample burst with header.
      stim_q = '{40'h0102030405, 40'hAABBCCDDEE, 40'h0};
      run_burst(1'b0, 0);
      wait_done(2000);
      check("b3_count", 64'(sample_count), 64'd3);
      check("b3_ovf", 64'(overflow), 64'd0);
      check("b3_busy", 64'(busy), 64'd0);

      // arm during CAPTURE must not disturb the burst.
      stim_q = '{40'h1122334455, 40'h66778899AA};
      run_burst(1'b1, 0);
      wait_done(2000);
      check("armcap_count", 64'(sample_count), 64'd2);

      // Empty burst: header only, no RAM reads.
      stim_q.delete();
      s0 = n_reads;
      run_burst(1'b0, 5);
      wait_done(500);
      check("empty_count", 64'(sample_count), 64'd0);
      check("empty_reads", 64'(n_reads - s0), 64'd0);

      // Overflow: 545 samples, 540 stored.
      busy_len = 2;
      stim_q.delete();
      for (int i = 0; i < 545; i++) stim_q.push_back({8'(i * 3), 32'(i * 32'h01010101)});
      s0 = n_writes;
      s1 = n_start;
      run_burst(1'b0, 0);
      wait_done(40000);
      check("ovf_writes", 64'(n_writes - s0), 64'd540);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_count", 64'(sample_count), 64'd540);
      check("ovf_starts", 64'(n_start - s1), 64'd2704);
      busy_len = 10;

      // UART busy at arm time: no start until it falls, one start per byte.
      hold_busy = 1'b1;
      stim_q = '{40'hDEADBEEF01};
      s0 = n_start;
      run_burst(1'b0, 0);
      repeat (190) @(negedge clk);
      check("hold_no_start", 64'(n_start - s0), 64'd0);
      hold_busy = 1'b0;
      wait_done(2000);
      check("hold_starts", 64'(n_start - s0), 64'd9);

      // abort during RD_WAIT.
      stim_q = '{40'h5555AAAA33};
      run_burst(1'b0, 0);
      g = 0;
      while (!ram_rden && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check("abort_saw_rden", 64'(ram_rden), 64'd1);
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_cnt", 64'(sample_count), 64'd0);
      exp_q.delete();
      s0 = n_start;
      repeat (100) @(negedge clk);
      check("abort_no_start", 64'(n_start - s0), 64'd0);

      // Fresh arm after abort completes a full frame.
      stim_q = '{40'h0F1E2D3C4B, 40'h8877665544};
      run_burst(1'b0, 0);
      wait_done(2000);
      check("rearm_count", 64'(sample_count), 64'd2);

      // Reset asserted mid-SEND.
      stim_q = '{40'hC0FFEE1234};
      s0 = n_start;
      run_burst(1'b0, 0);
      g = 0;
      while (n_start < s0 + 5 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check("rst_reached_send", 64'(n_start - s0), 64'd5);
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("rst_mid");
      exp_q.delete();
      wr_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      s0 = n_start;
      repeat (50) @(negedge clk);
      check("rst_no_start", 64'(n_start - s0), 64'd0);
      check("rst_idle_done", 64'(done), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
